// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo_if
//  Brief    : Consumer-side bundle of uart_rx_fifo: head entry, flags and
//             the four-phase Receive/ReceiveAck handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 Receive;
    logic                 ReceiveAck;
    logic [DATA_BITS-1:0] Dout;
    logic                 parityErr;
    logic                 framingErr;
    logic                 overrun;
    logic                 ClearErr;

    modport master (
        output Receive, Dout, parityErr, framingErr, overrun,
        input  ReceiveAck, ClearErr
    );

    modport slave (
        input  Receive, Dout, parityErr, framingErr, overrun,
        output ReceiveAck, ClearErr
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : Oversampling UART receiver with majority vote, parity/framing/
//             overrun flags and a FIFO drained by a four-phase handshake.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_EN     = 1,
    parameter int PARITY        = 1,
    parameter int STOP_BITS     = 1,
    parameter int OVERSAMPLE    = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           Sin,
    uart_rx_fifo_if.master bus
);
    localparam int c_div = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int c_tw  = (c_div > 2) ? $clog2(c_div) : 1;
    localparam int c_sw  = $clog2(OVERSAMPLE);
    localparam int c_aw  = $clog2(FIFO_DEPTH);
    localparam int c_ew  = DATA_BITS + 2;
    localparam int c_bw  = 4;
    localparam int c_mid = OVERSAMPLE / 2;

    generate
        if (c_div < 2) begin : g_div_check
            $error("uart_rx_fifo: CLK_FREQUENCY/(BAUD_RATE*OVERSAMPLE) must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_sync1, r_sync2, r_sync_prev;
    logic [c_tw-1:0]       r_tick_cnt;
    logic [c_sw-1:0]       r_samp_cnt;
    logic [c_bw-1:0]       r_bit_cnt;
    logic                  r_s0, r_s1;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_err, r_frm_err;
    logic                  r_push;
    logic [c_ew-1:0]       r_push_data;

    logic w_tick, w_vote, w_fall, w_vote_now, w_bit_end;

    assign w_tick     = (r_tick_cnt == c_tw'(c_div - 1));
    assign w_fall     = r_sync_prev & ~r_sync2;
    // Third sample is the live synchronised input at the vote tick.
    assign w_vote     = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign w_vote_now = w_tick && (r_samp_cnt == c_sw'(c_mid + 1));
    assign w_bit_end  = w_tick && (r_samp_cnt == c_sw'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
            r_tick_cnt  <= '0;
            r_samp_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_sync1     <= Sin;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_push      <= 1'b0;
            if (r_state == S_IDLE) begin
                // Counters held at zero so bit phase starts at the detected edge.
                r_tick_cnt <= '0;
                r_samp_cnt <= '0;
                r_bit_cnt  <= '0;
                if (w_fall) begin
                    r_state   <= S_START;
                    r_par_err <= 1'b0;
                    r_frm_err <= 1'b0;
                end
            end else begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                if (w_tick) begin
                    r_samp_cnt <= w_bit_end ? '0 : r_samp_cnt + 1'b1;
                    if (r_samp_cnt == c_sw'(c_mid - 1)) r_s0 <= r_sync2;
                    if (r_samp_cnt == c_sw'(c_mid))     r_s1 <= r_sync2;
                end
                case (r_state)
                    S_START: begin
                        if (w_vote_now && w_vote)
                            r_state <= S_IDLE;
                        else if (w_bit_end)
                            r_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (w_vote_now)
                            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (w_bit_end) begin
                            if (r_bit_cnt == c_bw'(DATA_BITS - 1)) begin
                                r_bit_cnt <= '0;
                                r_state   <= (PARITY_EN != 0) ? S_PAR : S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_PAR: begin
                        if (w_vote_now)
                            r_par_err <= (((^r_shift) ^ w_vote) != (PARITY != 0));
                        if (w_bit_end)
                            r_state <= S_STOP;
                    end
                    S_STOP: begin
                        if (w_vote_now) begin
                            if (r_bit_cnt == c_bw'(STOP_BITS - 1)) begin
                                r_push      <= 1'b1;
                                r_push_data <= {r_shift, r_par_err, r_frm_err | ~w_vote};
                                r_state     <= S_IDLE;
                            end else begin
                                r_frm_err <= r_frm_err | ~w_vote;
                            end
                        end
                        if (w_bit_end)
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- FIFO and consumer handshake ----------------
    logic [c_ew-1:0]      r_mem [FIFO_DEPTH];
    logic [c_aw:0]        r_wr_ptr, r_rd_ptr;
    logic                 r_ack_prev, r_ackd, r_receive, r_overrun;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_perr, r_ferr;
    logic                 w_empty, w_full, w_pop, w_wr, w_ackd_next;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                         (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_pop       = bus.ReceiveAck && !r_ack_prev && r_receive;
    // A pop frees the slot in the same cycle, so push+pop on full succeeds.
    assign w_wr        = r_push && (!w_full || w_pop);
    assign w_ackd_next = w_pop || (r_ackd && bus.ReceiveAck);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr[c_aw-1:0]] <= r_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ack_prev <= 1'b0;
            r_ackd     <= 1'b0;
            r_receive  <= 1'b0;
            r_overrun  <= 1'b0;
            r_dout     <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_ack_prev <= bus.ReceiveAck;
            r_ackd     <= w_ackd_next;
            r_receive  <= !w_empty && !w_ackd_next;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (!w_empty)
                {r_dout, r_perr, r_ferr} <= r_mem[r_rd_ptr[c_aw-1:0]];
            if (r_push && w_full && !w_pop)
                r_overrun <= 1'b1;
            else if (bus.ClearErr)
                r_overrun <= 1'b0;
        end
    end

    assign bus.Receive    = r_receive;
    assign bus.Dout       = r_dout;
    assign bus.parityErr  = r_perr;
    assign bus.framingErr = r_ferr;
    assign bus.overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Brief    : Self-checking bench for uart_rx_fifo against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int c_baud  = 19_200;
    localparam int c_os    = 16;
    localparam int c_div   = 4;
    localparam int c_clk   = c_baud * c_os * c_div;
    localparam int c_bit   = c_div * c_os;
    localparam int c_depth = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin_a = 1'b1;
    logic sin_b = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8)) ifa ();
    uart_rx_fifo_if #(.DATA_BITS(7)) ifb ();

    uart_rx_fifo #(
        .CLK_FREQUENCY(c_clk), .BAUD_RATE(c_baud), .DATA_BITS(8), .PARITY_EN(1),
        .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(c_os), .FIFO_DEPTH(c_depth)
    ) dut_a (.clk(clk), .rst(rst), .Sin(sin_a), .bus(ifa));

    uart_rx_fifo #(
        .CLK_FREQUENCY(c_clk), .BAUD_RATE(c_baud), .DATA_BITS(7), .PARITY_EN(0),
        .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(c_os), .FIFO_DEPTH(2)
    ) dut_b (.clk(clk), .rst(rst), .Sin(sin_b), .bus(ifb));

    typedef struct {
        logic [8:0] d;
        bit         p;
        bit         f;
    } ent_t;

    ent_t q[$];
    bit   exp_ovr = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic recv(input int sel);
        return (sel == 0) ? ifa.Receive : ifb.Receive;
    endfunction

    function automatic logic [31:0] dout(input int sel);
        return (sel == 0) ? 32'(ifa.Dout) : 32'(ifb.Dout);
    endfunction

    function automatic logic perr(input int sel);
        return (sel == 0) ? ifa.parityErr : ifb.parityErr;
    endfunction

    function automatic logic ferr(input int sel);
        return (sel == 0) ? ifa.framingErr : ifb.framingErr;
    endfunction

    task automatic set_ack(input int sel, input logic v);
        if (sel == 0) ifa.ReceiveAck = v;
        else          ifb.ReceiveAck = v;
    endtask

    task automatic drive_bit(input int sel, input logic v);
        if (sel == 0) sin_a = v;
        else          sin_b = v;
        repeat (c_bit) @(negedge clk);
    endtask

    // Frame builder; for line 0 the expected entry goes into the model.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit par_en, input bit par_bad, input int nstop,
                              input logic stop_v);
        int ones;
        ones = 0;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(sel, data[i]);
            if (data[i]) ones++;
        end
        if (par_en)
            drive_bit(sel, logic'((ones % 2) == 0) ^ par_bad);
        for (int i = 0; i < nstop; i++)
            drive_bit(sel, stop_v);
        drive_bit(sel, 1'b1);
        drive_bit(sel, 1'b1);
        if (sel == 0) begin
            if (q.size() == c_depth)
                exp_ovr = 1'b1;
            else
                q.push_back('{d: data, p: par_en && par_bad, f: (stop_v == 1'b0)});
        end
    endtask

    task automatic pop_check(input int sel, input logic [8:0] ed, input bit ep, input bit ef);
        int n;
        n = 0;
        while (!recv(sel) && n < 4 * c_bit) begin
            @(negedge clk);
            n++;
        end
        chk("rx_valid", 32'(recv(sel)), 1);
        chk("dout", dout(sel), 32'(ed));
        chk("parity_err", 32'(perr(sel)), 32'(ep));
        chk("framing_err", 32'(ferr(sel)), 32'(ef));
        set_ack(sel, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (recv(sel) && n < 20);
        chk("rx_release", 32'(recv(sel)), 0);
        repeat (3) @(negedge clk);
        chk("ack_held_no_repop", 32'(recv(sel)), 0);
        set_ack(sel, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_model();
        ent_t e;
        e = q.pop_front();
        pop_check(0, e.d, e.p, e.f);
    endtask

    initial begin
        logic [8:0]  d;
        logic [7:0]  part;
        logic [7:0]  dir_vals [8];
        bit          pb;
        logic        sv;

        dir_vals = '{8'hFF, 8'h00, 8'h0F, 8'hF0, 8'h37, 8'h73, 8'hAA, 8'h55};
        ifa.ReceiveAck = 1'b0; ifa.ClearErr = 1'b0;
        ifb.ReceiveAck = 1'b0; ifb.ClearErr = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_receive", 32'(ifa.Receive), 0);
        chk("rst_dout", 32'(ifa.Dout), 0);
        chk("rst_parity", 32'(ifa.parityErr), 0);
        chk("rst_framing", 32'(ifa.framingErr), 0);
        chk("rst_overrun", 32'(ifa.overrun), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean odd-parity frames.
        for (int i = 0; i < 8; i++) begin
            send_frame(0, {1'b0, dir_vals[i]}, 8, 1'b1, 1'b0, 1, 1'b1);
            pop_model();
        end

        // Parity error followed by clean frame.
        send_frame(0, 9'h037, 8, 1'b1, 1'b1, 1, 1'b1);
        send_frame(0, 9'h055, 8, 1'b1, 1'b0, 1, 1'b1);
        pop_model();
        pop_model();

        // Framing error followed by clean frame.
        send_frame(0, 9'h0A5, 8, 1'b1, 1'b0, 1, 1'b0);
        send_frame(0, 9'h05A, 8, 1'b1, 1'b0, 1, 1'b1);
        pop_model();
        pop_model();

        // Randomised frames with random error injection and random draining.
        for (int i = 0; i < 16; i++) begin
            d  = 9'($urandom_range(0, 255));
            pb = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            if (q.size() == c_depth) pop_model();
            send_frame(0, d, 8, 1'b1, pb, 1, sv);
            if ($urandom_range(0, 1) == 1) pop_model();
        end
        while (q.size() > 0) pop_model();
        chk("drained_empty", 32'(ifa.Receive), 0);
        chk("random_overrun", 32'(ifa.overrun), 32'(exp_ovr));

        // Short low glitch must be rejected as a false start.
        sin_a = 1'b0;
        repeat (2 * c_div) @(negedge clk);
        sin_a = 1'b1;
        repeat (2 * c_bit) @(negedge clk);
        chk("glitch_no_push", 32'(ifa.Receive), 0);
        send_frame(0, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1);
        pop_model();
        repeat (c_bit) @(negedge clk);
        chk("glitch_single_entry", 32'(ifa.Receive), 0);

        // Overrun: five frames into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 9'(i), 8, 1'b1, 1'b0, 1, 1'b1);
            if (i == 4) chk("overrun_before", 32'(ifa.overrun), 0);
        end
        chk("overrun_set", 32'(ifa.overrun), 32'(exp_ovr));
        while (q.size() > 0) pop_model();
        repeat (c_bit) @(negedge clk);
        chk("overrun_lost_frame", 32'(ifa.Receive), 0);
        chk("overrun_sticky", 32'(ifa.overrun), 1);
        ifa.ClearErr = 1'b1;
        @(negedge clk);
        ifa.ClearErr = 1'b0;
        @(negedge clk);
        exp_ovr = 1'b0;
        chk("overrun_cleared", 32'(ifa.overrun), 32'(exp_ovr));

        // Reset mid-frame discards the partial frame and the queued entry.
        send_frame(0, 9'h011, 8, 1'b1, 1'b0, 1, 1'b1);
        part = 8'h96;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, part[i]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sin_a = 1'b1;
        q.delete();
        @(negedge clk);
        chk("rst_mid_receive", 32'(ifa.Receive), 0);
        repeat (3 * c_bit) @(negedge clk);
        chk("rst_mid_no_entry", 32'(ifa.Receive), 0);
        send_frame(0, 9'h0C3, 8, 1'b1, 1'b0, 1, 1'b1);
        pop_model();

        // 7-bit, no parity, two stop bits.
        send_frame(1, 9'h055, 7, 1'b0, 1'b0, 2, 1'b1);
        pop_check(1, 9'h055, 1'b0, 1'b0);
        d = 9'($urandom_range(0, 127));
        send_frame(1, d, 7, 1'b0, 1'b0, 2, 1'b0);
        pop_check(1, d, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
